// File: rtl/playfield_arbiter.sv
// playfield_arbiter: answers movement requests with commit/declined/steal, locks landed pieces and serves display reads.
// Build option: define PLAYFIELD_LINE_CLEAR_EN to detect and remove full rows after each lock.

module playfield_arbiter #(
    parameter int ROWS = 20,
    parameter int COLS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       movement_request,
    input  logic       movement_intent,
    input  logic [4:0] P1blk_v,
    input  logic [4:0] P2blk_v,
    input  logic [4:0] P3blk_v,
    input  logic [4:0] P4blk_v,
    input  logic [4:0] P1blk_h,
    input  logic [4:0] P2blk_h,
    input  logic [4:0] P3blk_h,
    input  logic [4:0] P4blk_h,
    input  logic [2:0] volatile_blk_color,
    output logic       movement_commit,
    output logic       movement_declined,
    output logic       movement_steal,
    input  logic [4:0] rd_row,
    input  logic [4:0] rd_col,
    output logic [2:0] rd_color,
    output logic [7:0] lines_cleared,
    output logic       game_over,
    output logic       busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [4:0] ROWS5 = 5'(ROWS);
    localparam logic [4:0] COLS5 = 5'(COLS);

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_CHECK       = 4'd1;
    localparam logic [3:0] ST_RESP        = 4'd2;
    localparam logic [3:0] ST_WAIT_DROP   = 4'd3;
    localparam logic [3:0] ST_DECLINE     = 4'd4;
    localparam logic [3:0] ST_LOCK        = 4'd5;
    localparam logic [3:0] ST_STEAL       = 4'd6;
`ifdef PLAYFIELD_LINE_CLEAR_EN
    localparam logic [3:0] ST_CLEAR_SCAN  = 4'd7;
    localparam logic [3:0] ST_CLEAR_SHIFT = 4'd8;
`endif

    logic [3:0] state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       hit_q, hit_d;
    logic       intent_q;
    logic [4:0] blk_v_q [4];
    logic [4:0] blk_h_q [4];
    logic       commit_q, commit_d;
    logic       declined_q, declined_d;
    logic       steal_q, steal_d;
    logic       game_over_q, game_over_d;
    logic [2:0] cells_q [ROWS][COLS];
    logic [2:0] rd_color_q;

    logic [4:0] cur_v, cur_h, lock_h;
    logic       cur_in_range, cur_hit, lock_we;

    // The block under idx is shared by CHECK (collision test) and LOCK (write one row above).
    assign cur_v        = blk_v_q[idx_q];
    assign cur_h        = blk_h_q[idx_q];
    assign cur_in_range = (cur_v < COLS5) && (cur_h < ROWS5);
    assign cur_hit      = !cur_in_range || (cells_q[cur_h[RW-1:0]][cur_v[CW-1:0]] != 3'd0);
    assign lock_h       = cur_h - 5'd1;
    assign lock_we      = (cur_h != 5'd0) && (lock_h < ROWS5) && (cur_v < COLS5);

`ifdef PLAYFIELD_LINE_CLEAR_EN
    logic [4:0] scan_row_q, scan_row_d;
    logic [7:0] lines_q, lines_d;
    logic       row_full;

    always_comb begin
        row_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (cells_q[scan_row_q[RW-1:0]][c] == 3'd0) row_full = 1'b0;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        hit_d       = hit_q;
        commit_d    = 1'b0;
        declined_d  = declined_q;
        steal_d     = steal_q;
        game_over_d = game_over_q;
`ifdef PLAYFIELD_LINE_CLEAR_EN
        scan_row_d  = scan_row_q;
        lines_d     = lines_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (movement_request) begin
                    if (game_over_q) begin
                        declined_d = 1'b1;
                        state_d    = ST_DECLINE;
                    end else begin
                        idx_d   = 2'd0;
                        hit_d   = 1'b0;
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                hit_d = hit_q | cur_hit;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (!hit_q) begin
                    commit_d = 1'b1;
                    state_d  = ST_WAIT_DROP;
                end else if (intent_q) begin
                    declined_d = 1'b1;
                    state_d    = ST_DECLINE;
                end else begin
                    idx_d   = 2'd0;
                    state_d = ST_LOCK;
                end
            end
            ST_WAIT_DROP: begin
                if (!movement_request) state_d = ST_IDLE;
            end
            ST_DECLINE: begin
                if (!movement_request) begin
                    declined_d = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_LOCK: begin
                if ((cur_h == 5'd0) || (lock_we && lock_h == 5'd0)) game_over_d = 1'b1;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
`ifdef PLAYFIELD_LINE_CLEAR_EN
                    scan_row_d = ROWS5 - 5'd1;
                    state_d    = ST_CLEAR_SCAN;
`else
                    steal_d = 1'b1;
                    state_d = ST_STEAL;
`endif
                end
            end
`ifdef PLAYFIELD_LINE_CLEAR_EN
            ST_CLEAR_SCAN: begin
                if (row_full) begin
                    state_d = ST_CLEAR_SHIFT;
                end else if (scan_row_q == 5'd0) begin
                    steal_d = 1'b1;
                    state_d = ST_STEAL;
                end else begin
                    scan_row_d = scan_row_q - 5'd1;
                end
            end
            ST_CLEAR_SHIFT: begin
                // Row index is kept so a row that shifts into place full is caught on rescan.
                if (lines_q != 8'hFF) lines_d = lines_q + 8'd1;
                state_d = ST_CLEAR_SCAN;
            end
`endif
            ST_STEAL: begin
                if (!movement_request) begin
                    steal_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            hit_q       <= 1'b0;
            commit_q    <= 1'b0;
            declined_q  <= 1'b0;
            steal_q     <= 1'b0;
            game_over_q <= 1'b0;
`ifdef PLAYFIELD_LINE_CLEAR_EN
            scan_row_q  <= 5'd0;
            lines_q     <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            hit_q       <= hit_d;
            commit_q    <= commit_d;
            declined_q  <= declined_d;
            steal_q     <= steal_d;
            game_over_q <= game_over_d;
`ifdef PLAYFIELD_LINE_CLEAR_EN
            scan_row_q  <= scan_row_d;
            lines_q     <= lines_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intent_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                blk_v_q[i] <= 5'd0;
                blk_h_q[i] <= 5'd0;
            end
        end else if (state_q == ST_IDLE && movement_request) begin
            intent_q   <= movement_intent;
            blk_v_q[0] <= P1blk_v;
            blk_v_q[1] <= P2blk_v;
            blk_v_q[2] <= P3blk_v;
            blk_v_q[3] <= P4blk_v;
            blk_h_q[0] <= P1blk_h;
            blk_h_q[1] <= P2blk_h;
            blk_h_q[2] <= P3blk_h;
            blk_h_q[3] <= P4blk_h;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) cells_q[r][c] <= 3'd0;
            end
        end else begin
            if (state_q == ST_LOCK && lock_we) begin
                cells_q[lock_h[RW-1:0]][cur_v[CW-1:0]] <= volatile_blk_color;
            end
`ifdef PLAYFIELD_LINE_CLEAR_EN
            if (state_q == ST_CLEAR_SHIFT) begin
                for (int r = 1; r < ROWS; r++) begin
                    if (5'(r) <= scan_row_q) begin
                        for (int c = 0; c < COLS; c++) cells_q[r][c] <= cells_q[r-1][c];
                    end
                end
                for (int c = 0; c < COLS; c++) cells_q[0][c] <= 3'd0;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_color_q <= 3'd0;
        end else if (rd_row < ROWS5 && rd_col < COLS5) begin
            rd_color_q <= cells_q[rd_row[RW-1:0]][rd_col[CW-1:0]];
        end else begin
            rd_color_q <= 3'd0;
        end
    end

    assign movement_commit   = commit_q;
    assign movement_declined = declined_q;
    assign movement_steal    = steal_q;
    assign rd_color          = rd_color_q;
    assign game_over         = game_over_q;
    assign busy              = (state_q != ST_IDLE);
`ifdef PLAYFIELD_LINE_CLEAR_EN
    assign lines_cleared     = lines_q;
`else
    assign lines_cleared     = 8'd0;
`endif

endmodule

// File: tb/tb_playfield_arbiter.sv
// Scoreboard bench for playfield_arbiter: directed requests queue their expected response, a monitor pops and checks.
// Board and counter expectations follow the PLAYFIELD_LINE_CLEAR_EN build option.

module tb_playfield_arbiter;

`ifdef PLAYFIELD_LINE_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    localparam int K_COMMIT  = 1;
    localparam int K_DECLINE = 2;
    localparam int K_STEAL   = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       movement_request = 1'b0;
    logic       movement_intent = 1'b0;
    logic [4:0] P1blk_v = '0, P2blk_v = '0, P3blk_v = '0, P4blk_v = '0;
    logic [4:0] P1blk_h = '0, P2blk_h = '0, P3blk_h = '0, P4blk_h = '0;
    logic [2:0] volatile_blk_color = '0;
    logic       movement_commit, movement_declined, movement_steal;
    logic [4:0] rd_row = '0, rd_col = '0;
    logic [2:0] rd_color;
    logic [7:0] lines_cleared;
    logic       game_over, busy;

    typedef struct {
        int    kind;
        int    latency;
        string name;
    } exp_t;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount = 0;
    int   edgeCount = 0;
    int   reqEdge = 0;
    int   monKind;
    exp_t monExp;
    logic prevC = 1'b0, prevD = 1'b0, prevS = 1'b0;

    playfield_arbiter #(.ROWS(20), .COLS(10)) dut (
        .clk(clk),
        .reset(reset),
        .movement_request(movement_request),
        .movement_intent(movement_intent),
        .P1blk_v(P1blk_v),
        .P2blk_v(P2blk_v),
        .P3blk_v(P3blk_v),
        .P4blk_v(P4blk_v),
        .P1blk_h(P1blk_h),
        .P2blk_h(P2blk_h),
        .P3blk_h(P3blk_h),
        .P4blk_h(P4blk_h),
        .volatile_blk_color(volatile_blk_color),
        .movement_commit(movement_commit),
        .movement_declined(movement_declined),
        .movement_steal(movement_steal),
        .rd_row(rd_row),
        .rd_col(rd_col),
        .rd_color(rd_color),
        .lines_cleared(lines_cleared),
        .game_over(game_over),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: every rising handshake output consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            prevC = 1'b0;
            prevD = 1'b0;
            prevS = 1'b0;
        end else begin
            if (prevC) checkOutput("commit_single_cycle", int'(movement_commit), 0);
            if ((movement_commit && !prevC) || (movement_declined && !prevD) || (movement_steal && !prevS)) begin
                monKind = movement_commit ? K_COMMIT : (movement_declined ? K_DECLINE : K_STEAL);
                checkOutput("outputs_one_hot", $countones({movement_commit, movement_declined, movement_steal}), 1);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_response", monKind, 0);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput({monExp.name, "_kind"}, monKind, monExp.kind);
                    if (monExp.latency >= 0)
                        checkOutput({monExp.name, "_latency"}, edgeCount - reqEdge, monExp.latency);
                end
            end
            prevC = movement_commit;
            prevD = movement_declined;
            prevS = movement_steal;
        end
    end

    task automatic applyStimulus(input string name, input logic intent,
                                 input logic [4:0] h0, input logic [4:0] h1, input logic [4:0] h2, input logic [4:0] h3,
                                 input logic [4:0] v0, input logic [4:0] v1, input logic [4:0] v2, input logic [4:0] v3,
                                 input logic [2:0] color, input int kind, input int lat);
        exp_t e;
        int   waited;
        @(negedge clk);
        e.kind = kind;
        e.latency = lat;
        e.name = name;
        expQ.push_back(e);
        movement_intent = intent;
        P1blk_h = h0; P2blk_h = h1; P3blk_h = h2; P4blk_h = h3;
        P1blk_v = v0; P2blk_v = v1; P3blk_v = v2; P4blk_v = v3;
        volatile_blk_color = color;
        movement_request = 1'b1;
        reqEdge = edgeCount + 1;
        waited = 0;
        while (!(movement_commit || movement_declined || movement_steal) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) checkOutput({name, "_response_timeout"}, 0, 1);
    endtask

    task automatic dropRequest(input string name, input int hold);
        int waited;
        repeat (hold) @(negedge clk);
        movement_request = 1'b0;
        @(negedge clk);
        checkOutput({name, "_level_drop"}, int'({movement_declined, movement_steal}), 0);
        waited = 0;
        while (busy && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({name, "_back_to_idle"}, int'(busy), 0);
    endtask

    task automatic readCell(input string name, input logic [4:0] row, input logic [4:0] col, input int expected);
        @(negedge clk);
        rd_row = row;
        rd_col = col;
        @(negedge clk);
        checkOutput(name, int'(rd_color), expected);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("reset_commit", int'(movement_commit), 0);
        checkOutput("reset_declined", int'(movement_declined), 0);
        checkOutput("reset_steal", int'(movement_steal), 0);
        checkOutput("reset_game_over", int'(game_over), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_lines", int'(lines_cleared), 0);
        checkOutput("reset_rd_color", int'(rd_color), 0);
        reset = 1'b1;

        // Free placement on an empty board; holding the request must not produce a second commit.
        applyStimulus("t1_commit", 1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7, 3'd2, K_COMMIT, 5);
        dropRequest("t1", 4);

        // Wrapped column on a player move is declined and leaves the board alone.
        applyStimulus("t2_wrap", 1'b1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd31, 5'd4, 5'd5, 5'd6, 3'd2, K_DECLINE, 5);
        repeat (3) @(negedge clk);
        checkOutput("t2_declined_held", int'(movement_declined), 1);
        dropRequest("t2", 0);
        readCell("t2_no_write", 5'd0, 5'd4, 0);
        checkOutput("t2_game_over", int'(game_over), 0);

        // Falling below the floor locks into row 19.
        applyStimulus("t3_lock", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd4, 5'd5, 5'd6, 5'd7, 3'd3, K_STEAL, -1);
        repeat (2) @(negedge clk);
        checkOutput("t3_steal_held", int'(movement_steal), 1);
        dropRequest("t3", 0);
        readCell("t3_cell_19_4", 5'd19, 5'd4, 3);
        readCell("t3_cell_19_7", 5'd19, 5'd7, 3);
        readCell("t3_cell_18_4", 5'd18, 5'd4, 0);
        checkOutput("t3_lines", int'(lines_cleared), 0);

        applyStimulus("t4_fill_a", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd0, 5'd1, 5'd2, 5'd3, 3'd5, K_STEAL, -1);
        dropRequest("t4a", 1);
        applyStimulus("t4_fill_b", 1'b0, 5'd19, 5'd19, 5'd19, 5'd19, 5'd0, 5'd1, 5'd2, 5'd3, 3'd2, K_STEAL, -1);
        dropRequest("t4b", 1);
        readCell("t4_row18_marker", 5'd18, 5'd0, 2);

        // I piece completes row 19; with clearing the old row 18 drops into row 19.
        applyStimulus("t4_i_piece", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd6, 5'd7, 5'd8, 5'd9, 3'd1, K_STEAL, -1);
        dropRequest("t4", 1);
        checkOutput("t4_lines", int'(lines_cleared), CLR ? 1 : 0);
        readCell("t4_cell_19_0", 5'd19, 5'd0, CLR ? 2 : 5);
        readCell("t4_cell_19_4", 5'd19, 5'd4, CLR ? 0 : 3);
        readCell("t4_cell_19_9", 5'd19, 5'd9, CLR ? 0 : 1);
        readCell("t4_cell_18_0", 5'd18, 5'd0, CLR ? 0 : 2);

        // Build rows 18 and 19 up to column 7, then one vertical lock fills both.
        applyStimulus("t5_fill_a", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd4, 5'd5, 5'd6, 5'd7, 3'd4, K_STEAL, -1);
        dropRequest("t5a", 1);
        applyStimulus("t5_fill_b", 1'b0, 5'd19, 5'd19, 5'd19, 5'd19, 5'd0, 5'd1, 5'd2, 5'd3, 3'd6, K_STEAL, -1);
        dropRequest("t5b", 1);
        applyStimulus("t5_fill_c", 1'b0, 5'd19, 5'd19, 5'd19, 5'd19, 5'd4, 5'd5, 5'd6, 5'd7, 3'd6, K_STEAL, -1);
        dropRequest("t5c", 1);
        applyStimulus("t5_double", 1'b0, 5'd19, 5'd20, 5'd19, 5'd20, 5'd8, 5'd8, 5'd9, 5'd9, 3'd7, K_STEAL, -1);
        dropRequest("t5", 1);
        checkOutput("t5_lines", int'(lines_cleared), CLR ? 3 : 0);
        readCell("t5_cell_19_0", 5'd19, 5'd0, CLR ? 0 : 5);
        readCell("t5_cell_19_9", 5'd19, 5'd9, CLR ? 0 : 7);
        readCell("t5_cell_18_9", 5'd18, 5'd9, CLR ? 0 : 7);
        readCell("t5_cell_18_5", 5'd18, 5'd5, CLR ? 0 : 6);

        // Locking into row 0 ends the game.
        applyStimulus("t6_top_lock", 1'b0, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd2, 5'd31, 3'd3, K_STEAL, -1);
        dropRequest("t6", 1);
        checkOutput("t6_game_over", int'(game_over), 1);
        readCell("t6_cell_0_0", 5'd0, 5'd0, 3);
        readCell("t6_rd_col_range", 5'd0, 5'd16, 0);
        readCell("t6_rd_row_range", 5'd20, 5'd0, 0);

        applyStimulus("t7_go_player", 1'b1, 5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd1, 5'd2, 5'd3, 3'd1, K_DECLINE, -1);
        dropRequest("t7", 1);
        applyStimulus("t8_go_fall", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd4, 5'd5, 5'd6, 5'd7, 3'd2, K_DECLINE, -1);
        dropRequest("t8", 1);
        readCell("t8_no_lock", 5'd19, 5'd5, CLR ? 0 : 4);
        checkOutput("t8_lines_kept", int'(lines_cleared), CLR ? 3 : 0);

        // Reset while declined is held drops everything without waiting for a clock.
        applyStimulus("t9_reset_mid", 1'b0, 5'd20, 5'd20, 5'd20, 5'd20, 5'd0, 5'd1, 5'd2, 5'd3, 3'd2, K_DECLINE, -1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("t9_async_declined", int'(movement_declined), 0);
        checkOutput("t9_async_busy", int'(busy), 0);
        checkOutput("t9_async_game_over", int'(game_over), 0);
        checkOutput("t9_async_lines", int'(lines_cleared), 0);
        movement_request = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        readCell("t9_board_cleared_0_0", 5'd0, 5'd0, 0);
        readCell("t9_board_cleared_19_5", 5'd19, 5'd5, 0);
        checkOutput("t9_game_over_after", int'(game_over), 0);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
